// File: rtl/host_mon_if.sv
// Host bus monitor front end: classifies 8080-style bus cycles,
// optionally run-compresses memory accesses and queues trace entries.
module host_mon_if #(
  parameter int DW = 8,
  parameter int AW = 11,
  parameter int CW = 14,
  parameter int FL = 2,
  parameter int MODE = 0,
  parameter logic [DW-1:0] TRIG_CMD = DW'(8'h40),
  parameter logic [DW-1:0] MWR_CMD = DW'(8'h42),
  parameter logic [DW-1:0] MRD_CMD = DW'(8'h43),
  parameter int RUN_EN = 1
) (
  input  logic          clk,
  input  logic          rst_x,
  input  logic          ce_x,
  input  logic          a0,
  input  logic          wr_x,
  input  logic          rd_x,
  input  logic [DW-1:0] dat,
  input  logic          clr,
  input  logic          flush,
  output logic          wrreq,
  input  logic          wrack,
  output logic [AW-1:0] waddr,
  output logic [4+CW-1:0] wdata,
  output logic          ovf
);

  localparam int EW = 4 + CW;
  localparam int DEPTH = 1 << FL;
  localparam logic [CW-1:0] CNT_MAX = '1;

  localparam logic [3:0] T_WCMD = 4'd1;
  localparam logic [3:0] T_WDAT = 4'd2;
  localparam logic [3:0] T_RDAT = 4'd3;
  localparam logic [3:0] T_WMEM = 4'd4;
  localparam logic [3:0] T_RMEM = 4'd5;
  localparam logic [3:0] T_RSTA = 4'd6;
  localparam logic [3:0] T_RUNW = 4'd8;
  localparam logic [3:0] T_RUNR = 4'd9;

  localparam logic [DW+3:0] SYNC_RST = {4'b1011, {DW{1'b0}}};

  typedef enum logic [1:0] {IDLE, SETUP, HOLD} st_t;

  logic [DW+3:0] s1_q, s2_q;
  logic          s_ce, s_a0, s_wr, s_rd;
  logic [DW-1:0] s_dat;

  st_t           st_q, st_d;
  logic          wsel_q, wsel_d;
  logic [DW-1:0] cmd_q, cmd_d;
  logic          arm_q, arm_d;

  logic [3:0]    ev_type;
  logic          ev;
  logic [EW-1:0] ev_data;
  logic          is_mem, ev_rd;

  logic          run_q, run_d;
  logic          run_rd_q, run_rd_d;
  logic [CW-1:0] rcnt_q, rcnt_d, rcnt_inc;
  logic          pend_q, pend_d;
  logic [EW-1:0] pdat_q, pdat_d;
  logic [EW-1:0] run_word;

  logic          push;
  logic [EW-1:0] push_data;

  logic [EW-1:0] mem_q [DEPTH];
  logic [FL-1:0] wp_q, rp_q;
  logic [FL:0]   cnt_q;
  logic [AW-1:0] addr_q;
  logic          ovf_q;
  logic          empty, full, pop, do_push, drop;

  assign {s_ce, s_a0, s_wr, s_rd, s_dat} = s2_q;

  // Two-stage synchroniser on the asynchronous host bus
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      s1_q <= SYNC_RST;
      s2_q <= SYNC_RST;
    end else begin
      s1_q <= {ce_x, a0, wr_x, rd_x, dat};
      s2_q <= s1_q;
    end
  end

  // Bus cycle FSM; the strobe kind is latched on cycle start
  always_comb begin
    st_d = st_q;
    wsel_d = wsel_q;
    unique case (st_q)
      IDLE: if (!s_ce && (!s_wr || !s_rd)) begin
        st_d = SETUP;
        wsel_d = !s_wr;
      end
      SETUP: st_d = HOLD;
      HOLD: if (s_ce || (s_wr && s_rd)) st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  // Classify the cycle and apply the capture gate during SETUP
  always_comb begin
    ev_type = T_RSTA;
    ev = 1'b0;
    cmd_d = cmd_q;
    arm_d = arm_q;
    if (st_q == SETUP) begin
      if (wsel_q) begin
        if (s_a0) begin
          ev_type = T_WCMD;
          cmd_d = s_dat;
        end else begin
          ev_type = (cmd_q == MWR_CMD) ? T_WMEM : T_WDAT;
        end
      end else begin
        if (s_a0) ev_type = (cmd_q == MRD_CMD) ? T_RMEM : T_RDAT;
        else ev_type = T_RSTA;
      end
      if (MODE != 0) begin
        ev = 1'b1;
      end else if (ev_type == T_WCMD) begin
        ev = (s_dat == TRIG_CMD);
        arm_d = ev;
      end else begin
        ev = arm_q;
      end
    end
    if (clr) arm_d = 1'b0;
  end

  assign ev_data = {ev_type, CW'(s_dat)};
  assign is_mem = (ev_type == T_WMEM) || (ev_type == T_RMEM);
  assign ev_rd = (ev_type == T_RMEM);
  assign rcnt_inc = rcnt_q + CW'(1);
  assign run_word = {run_rd_q ? T_RUNR : T_RUNW, rcnt_q};

  // Run compression and ordering of pushes into the FIFO
  always_comb begin
    push = 1'b0;
    push_data = ev_data;
    run_d = run_q;
    run_rd_d = run_rd_q;
    rcnt_d = rcnt_q;
    pend_d = pend_q;
    pdat_d = pdat_q;
    if (pend_q) begin
      push = 1'b1;
      push_data = pdat_q;
      pend_d = 1'b0;
    end else if (ev && is_mem && (RUN_EN != 0)) begin
      if (run_q && (run_rd_q == ev_rd) && !flush) begin
        rcnt_d = rcnt_inc;
        if (rcnt_inc == CNT_MAX) begin
          push = 1'b1;
          push_data = {run_rd_q ? T_RUNR : T_RUNW, rcnt_inc};
          run_d = 1'b0;
        end
      end else begin
        if (run_q) begin
          push = 1'b1;
          push_data = run_word;
        end
        run_d = 1'b1;
        run_rd_d = ev_rd;
        rcnt_d = CW'(1);
      end
    end else if (ev) begin
      push = 1'b1;
      if (run_q) begin
        push_data = run_word;
        run_d = 1'b0;
        pend_d = 1'b1;
        pdat_d = ev_data;
      end
    end else if (flush && run_q) begin
      push = 1'b1;
      push_data = run_word;
      run_d = 1'b0;
    end
    if (clr) begin
      run_d = 1'b0;
      pend_d = 1'b0;
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      st_q <= IDLE;
      wsel_q <= 1'b0;
      cmd_q <= '0;
      arm_q <= 1'b0;
      run_q <= 1'b0;
      run_rd_q <= 1'b0;
      rcnt_q <= '0;
      pend_q <= 1'b0;
      pdat_q <= '0;
    end else begin
      st_q <= st_d;
      wsel_q <= wsel_d;
      cmd_q <= cmd_d;
      arm_q <= arm_d;
      run_q <= run_d;
      run_rd_q <= run_rd_d;
      rcnt_q <= rcnt_d;
      pend_q <= pend_d;
      pdat_q <= pdat_d;
    end
  end

  assign empty = (cnt_q == '0);
  assign full = (cnt_q == (FL+1)'(DEPTH));
  assign pop = !empty && wrack;
  assign do_push = push && (!full || pop);
  assign drop = push && full && !pop;

  // FIFO pointers, trace address and sticky overflow
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      addr_q <= '0;
      ovf_q <= 1'b0;
    end else if (clr) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      addr_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (do_push) wp_q <= wp_q + FL'(1);
      if (pop) begin
        rp_q <= rp_q + FL'(1);
        addr_q <= addr_q + AW'(1);
      end
      unique case ({do_push, pop})
        2'b10: cnt_q <= cnt_q + (FL+1)'(1);
        2'b01: cnt_q <= cnt_q - (FL+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (drop) ovf_q <= 1'b1;
    end
  end

  // FIFO storage
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push && !clr) begin
      mem_q[wp_q] <= push_data;
    end
  end

  assign wrreq = !empty;
  assign wdata = empty ? '0 : mem_q[rp_q];
  assign waddr = addr_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_host_mon_if.sv
// Directed bench for host_mon_if: four parameter variants share
// one host bus, each with its own trace write port.
module tb_host_mon_if;

  logic clk = 1'b0;
  logic rst_x = 1'b0;
  logic ce_x = 1'b1;
  logic a0 = 1'b0;
  logic wr_x = 1'b1;
  logic rd_x = 1'b1;
  logic clr = 1'b0;
  logic flush = 1'b0;
  logic [7:0] dat = 8'h00;
  logic [3:0] wrack = 4'h0;
  logic [3:0] wrreq;
  logic [3:0] ovf;
  logic [10:0] waddr [4];
  logic [17:0] wd0, wd1, wd2;
  logic [6:0] wd3;
  logic [3:0] typ [4];
  logic [13:0] pay [4];
  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  host_mon_if #(.MODE(0)) u0 (
    .clk(clk), .rst_x(rst_x), .ce_x(ce_x), .a0(a0), .wr_x(wr_x),
    .rd_x(rd_x), .dat(dat), .clr(clr), .flush(flush),
    .wrreq(wrreq[0]), .wrack(wrack[0]), .waddr(waddr[0]),
    .wdata(wd0), .ovf(ovf[0]));

  host_mon_if #(.MODE(1)) u1 (
    .clk(clk), .rst_x(rst_x), .ce_x(ce_x), .a0(a0), .wr_x(wr_x),
    .rd_x(rd_x), .dat(dat), .clr(clr), .flush(flush),
    .wrreq(wrreq[1]), .wrack(wrack[1]), .waddr(waddr[1]),
    .wdata(wd1), .ovf(ovf[1]));

  host_mon_if #(.MODE(1), .RUN_EN(0)) u2 (
    .clk(clk), .rst_x(rst_x), .ce_x(ce_x), .a0(a0), .wr_x(wr_x),
    .rd_x(rd_x), .dat(dat), .clr(clr), .flush(flush),
    .wrreq(wrreq[2]), .wrack(wrack[2]), .waddr(waddr[2]),
    .wdata(wd2), .ovf(ovf[2]));

  host_mon_if #(.DW(3), .CW(3), .MODE(1), .TRIG_CMD(3'd0),
    .MWR_CMD(3'd2), .MRD_CMD(3'd3)) u3 (
    .clk(clk), .rst_x(rst_x), .ce_x(ce_x), .a0(a0), .wr_x(wr_x),
    .rd_x(rd_x), .dat(dat[2:0]), .clr(clr), .flush(flush),
    .wrreq(wrreq[3]), .wrack(wrack[3]), .waddr(waddr[3]),
    .wdata(wd3), .ovf(ovf[3]));

  assign typ[0] = wd0[17:14];
  assign pay[0] = wd0[13:0];
  assign typ[1] = wd1[17:14];
  assign pay[1] = wd1[13:0];
  assign typ[2] = wd2[17:14];
  assign pay[2] = wd2[13:0];
  assign typ[3] = wd3[6:3];
  assign pay[3] = {11'b0, wd3[2:0]};

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus(input logic a, input logic [7:0] d, input logic rd);
    @(negedge clk);
    ce_x = 1'b0;
    a0 = a;
    dat = d;
    if (rd) rd_x = 1'b0;
    else wr_x = 1'b0;
    repeat (4) @(negedge clk);
    wr_x = 1'b1;
    rd_x = 1'b1;
    ce_x = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic clr_p();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic flush_p();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic pop(input int k, input logic [3:0] t,
                     input logic [13:0] p, input logic [10:0] a);
    int n;
    n = 0;
    @(negedge clk);
    while (!wrreq[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("u%0d.req", k), 32'(wrreq[k]), 32'd1);
    check($sformatf("u%0d.type@%0d", k, a), 32'(typ[k]), 32'(t));
    check($sformatf("u%0d.pay@%0d", k, a), 32'(pay[k]), 32'(p));
    check($sformatf("u%0d.addr", k), 32'(waddr[k]), 32'(a));
    wrack[k] = 1'b1;
    @(negedge clk);
    wrack[k] = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst.req_in", 32'(wrreq), 32'h0);
    rst_x = 1'b1;
    @(negedge clk);
    check("rst.req", 32'(wrreq), 32'h0);
    check("rst.ovf", 32'(ovf), 32'h0);
    check("rst.addr", 32'(waddr[0]), 32'h0);
    check("rst.wdata", 32'(wd0), 32'h0);

    // trigger capture: arm, two data, disarm, ignored data
    clr_p();
    bus(1'b1, 8'h40, 1'b0);
    bus(1'b0, 8'h12, 1'b0);
    bus(1'b0, 8'h34, 1'b0);
    bus(1'b1, 8'h10, 1'b0);
    bus(1'b0, 8'h56, 1'b0);
    pop(0, 4'd1, 14'h40, 11'd0);
    pop(0, 4'd2, 14'h12, 11'd1);
    pop(0, 4'd2, 14'h34, 11'd2);
    repeat (2) @(negedge clk);
    check("t1.idle", 32'(wrreq[0]), 32'd0);
    check("t1.ovf", 32'(ovf[0]), 32'd0);

    // run of five memory writes closed by a command
    clr_p();
    bus(1'b1, 8'h42, 1'b0);
    for (int i = 0; i < 5; i++) bus(1'b0, 8'hA0 + 8'(i), 1'b0);
    bus(1'b1, 8'h43, 1'b0);
    pop(1, 4'd1, 14'h42, 11'd0);
    pop(1, 4'd8, 14'd5, 11'd1);
    pop(1, 4'd1, 14'h43, 11'd2);

    // status read with latency check
    clr_p();
    @(negedge clk);
    ce_x = 1'b0;
    a0 = 1'b0;
    dat = 8'h60;
    rd_x = 1'b0;
    repeat (3) @(negedge clk);
    check("t3.lat_early", 32'(wrreq[1]), 32'd0);
    @(negedge clk);
    check("t3.lat_push", 32'(wrreq[1]), 32'd1);
    rd_x = 1'b1;
    ce_x = 1'b1;
    repeat (4) @(negedge clk);
    pop(1, 4'd6, 14'h60, 11'd0);

    // memory read without run compression
    clr_p();
    bus(1'b1, 8'h43, 1'b0);
    bus(1'b1, 8'h77, 1'b1);
    pop(2, 4'd1, 14'h43, 11'd0);
    pop(2, 4'd5, 14'h77, 11'd1);

    // overflow: six events into a four-deep FIFO
    clr_p();
    for (int i = 0; i < 6; i++) bus(1'b1, 8'h11 + 8'(i), 1'b0);
    check("t4.ovf", 32'(ovf[2]), 32'd1);
    for (int i = 0; i < 4; i++) pop(2, 4'd1, 14'h11 + 14'(i), 11'(i));
    @(negedge clk);
    check("t4.empty", 32'(wrreq[2]), 32'd0);
    check("t4.ovf_sticky", 32'(ovf[2]), 32'd1);

    // run counter saturation at 2^CW-1 with CW=3
    clr_p();
    bus(1'b1, 8'h02, 1'b0);
    for (int i = 0; i < 8; i++) bus(1'b0, 8'h05, 1'b0);
    pop(3, 4'd1, 14'd2, 11'd0);
    pop(3, 4'd8, 14'd7, 11'd1);
    repeat (2) @(negedge clk);
    check("t5.pending", 32'(wrreq[3]), 32'd0);
    flush_p();
    pop(3, 4'd8, 14'd1, 11'd2);

    // trace address wrap, with wrack held during empty periods
    clr_p();
    wrack[2] = 1'b1;
    for (int i = 0; i < 2047; i++) bus(1'b1, 8'(i), 1'b0);
    wrack[2] = 1'b0;
    check("t6.addr_top", 32'(waddr[2]), 32'h7FF);
    check("t6.empty", 32'(wrreq[2]), 32'd0);
    bus(1'b1, 8'hAB, 1'b0);
    pop(2, 4'd1, 14'hAB, 11'h7FF);
    check("t6.wrap", 32'(waddr[2]), 32'd0);

    // asynchronous reset in the middle of a held cycle
    clr_p();
    bus(1'b1, 8'h21, 1'b0);
    pop(1, 4'd1, 14'h21, 11'd0);
    bus(1'b1, 8'h22, 1'b0);
    check("t7.pre_req", 32'(wrreq[1]), 32'd1);
    check("t7.pre_addr", 32'(waddr[1]), 32'd1);
    @(negedge clk);
    ce_x = 1'b0;
    a0 = 1'b1;
    dat = 8'h33;
    wr_x = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_x = 1'b0;
    #1;
    check("t7.req", 32'(wrreq[1]), 32'd0);
    check("t7.addr", 32'(waddr[1]), 32'd0);
    check("t7.wdata", 32'(wd1), 32'd0);
    check("t7.ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    wr_x = 1'b1;
    ce_x = 1'b1;
    repeat (2) @(negedge clk);
    rst_x = 1'b1;
    repeat (3) @(negedge clk);
    bus(1'b1, 8'h55, 1'b0);
    pop(1, 4'd1, 14'h55, 11'd0);
    @(negedge clk);
    check("t7.empty", 32'(wrreq[1]), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
